// File: rtl/qam_demodulator.sv
// rtl/qam_demodulator.sv - 16-QAM symbol slicer, 4-bit serializer and m-sequence lock checker
//
// Ports:
//   clk        in   1   sole clock, rising edge
//   rst        in   1   synchronous active-high reset
//   sym_valid  in   1   Siga/Sigb carry a new symbol this cycle
//   Siga       in   3   in-phase level, two's complement
//   Sigb       in   3   quadrature level, two's complement
//   SigI       out  2   sliced in-phase Gray dibit (registered)
//   SigQ       out  2   sliced quadrature Gray dibit (registered)
//   bit_out    out  1   recovered serial bit, MSB of SigI first
//   bit_valid  out  1   qualifies bit_out
//   m_align    out  1   checker is locked to the 3-stage m-sequence
//   overrun    out  1   one-cycle pulse after a dropped symbol
//   err_cnt    out  16  saturating bit-error count while locked
//
// Build option: QAM_DEMOD_ERRCNT_EN enables the err_cnt counter; when it is
// undefined err_cnt is tied to zero and no counter is built.

module qam_demodulator (
  input  logic        clk,
  input  logic        rst,
  input  logic        sym_valid,
  input  logic [2:0]  Siga,
  input  logic [2:0]  Sigb,
  output logic [1:0]  SigI,
  output logic [1:0]  SigQ,
  output logic        bit_out,
  output logic        bit_valid,
  output logic        m_align,
  output logic        overrun,
  output logic [15:0] err_cnt
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_t;

  // Gray slicer: <=-2 -> 00, -1 -> 01, 0/+1 -> 11, >=+2 -> 10.
  function automatic logic [1:0] slice(input logic [2:0] v);
    logic [1:0] d;
    case (v)
      3'b000, 3'b001: d = 2'b11;
      3'b010, 3'b011: d = 2'b10;
      3'b111:         d = 2'b01;
      default:        d = 2'b00;  // -4, -3, -2
    endcase
    return d;
  endfunction

  // ---------------------------------------------------------------------------
  // Slicer and serializer
  // ---------------------------------------------------------------------------
  logic [1:0] slice_i;
  logic [1:0] slice_q;
  logic [2:0] sh;        // bits still to be shifted out, next one in sh[2]
  logic [1:0] pending;   // number of valid bits left in sh
  logic       accept;

  assign slice_i = slice(Siga);
  assign slice_q = slice(Sigb);

  // pending reaches 0 on the cycle the last bit sits on bit_out, so a new
  // symbol arriving then is taken and the bit streams abut with no gap.
  assign accept = sym_valid && (pending == 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      SigI      <= 2'b00;
      SigQ      <= 2'b00;
      sh        <= 3'b000;
      pending   <= 2'd0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= sym_valid && (pending != 2'd0);
      if (accept) begin
        SigI      <= slice_i;
        SigQ      <= slice_q;
        bit_out   <= slice_i[1];
        bit_valid <= 1'b1;
        sh        <= {slice_i[0], slice_q};
        pending   <= 2'd3;
      end else if (pending != 2'd0) begin
        bit_out   <= sh[2];
        bit_valid <= 1'b1;
        sh        <= {sh[1:0], 1'b0};
        pending   <= pending - 2'd1;
      end else begin
        bit_valid <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // m-sequence checker (x^3 + x + 1 style: next = r[2] ^ r[1])
  // ---------------------------------------------------------------------------
  chk_state_t state, state_n;
  logic [2:0] r, r_n;
  logic [1:0] fill_cnt, fill_n;
  logic [2:0] match_cnt, match_n;
  logic [1:0] miss_cnt, miss_n;
  logic       pred;
  logic       mismatch;

  assign pred     = r[2] ^ r[1];
  assign mismatch = bit_out ^ pred;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      r         <= 3'b000;
      fill_cnt  <= 2'd0;
      match_cnt <= 3'd0;
      miss_cnt  <= 2'd0;
      m_align   <= 1'b0;
    end else begin
      state     <= state_n;
      r         <= r_n;
      fill_cnt  <= fill_n;
      match_cnt <= match_n;
      miss_cnt  <= miss_n;
      // Tracks the state being entered so m_align lines up with the first
      // cycle spent in LOCKED and drops on the first cycle out of it.
      m_align   <= (state_n == LOCKED);
    end
  end

  always_comb begin
    state_n = state;
    r_n     = r;
    fill_n  = fill_cnt;
    match_n = match_cnt;
    miss_n  = miss_cnt;
    if (bit_valid) begin
      case (state)
        HUNT: begin
          r_n = {r[1:0], bit_out};
          if (fill_cnt == 2'd2) begin
            // A zero register would predict zeros forever; refill instead.
            fill_n = 2'd0;
            if (r_n != 3'b000) begin
              state_n = VERIFY;
              match_n = 3'd0;
            end
          end else begin
            fill_n = fill_cnt + 2'd1;
          end
        end
        VERIFY: begin
          r_n = {r[1:0], bit_out};
          if (mismatch) begin
            state_n = HUNT;
            fill_n  = 2'd0;
          end else if (match_cnt == 3'd6) begin
            state_n = LOCKED;
            match_n = 3'd0;
            miss_n  = 2'd0;
          end else begin
            match_n = match_cnt + 3'd1;
          end
        end
        LOCKED: begin
          // Flywheel: run on the local prediction so a corrupted bit does
          // not poison the register.
          r_n = {r[1:0], pred};
          if (mismatch) begin
            if (miss_cnt == 2'd2) begin
              state_n = HUNT;
              fill_n  = 2'd0;
              miss_n  = 2'd0;
            end else begin
              miss_n = miss_cnt + 2'd1;
            end
          end else begin
            miss_n = 2'd0;
          end
        end
        default: begin
          state_n = HUNT;
          fill_n  = 2'd0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Error counter
  // ---------------------------------------------------------------------------
`ifdef QAM_DEMOD_ERRCNT_EN
  logic        err_inc;
  logic [15:0] err_q;

  assign err_inc = bit_valid && (state == LOCKED) && mismatch;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 16'd0;
    end else if (err_inc && (err_q != 16'hFFFF)) begin
      err_q <= err_q + 16'd1;
    end
  end

  assign err_cnt = err_q;
`else
  assign err_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_qam_demodulator.sv
// tb/tb_qam_demodulator.sv - directed self-checking bench for qam_demodulator

module tb_qam_demodulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        sym_valid;
  logic [2:0]  Siga;
  logic [2:0]  Sigb;
  logic [1:0]  SigI;
  logic [1:0]  SigQ;
  logic        bit_out;
  logic        bit_valid;
  logic        m_align;
  logic        overrun;
  logic [15:0] err_cnt;

  qam_demodulator dut (
    .clk       (clk),
    .rst       (rst),
    .sym_valid (sym_valid),
    .Siga      (Siga),
    .Sigb      (Sigb),
    .SigI      (SigI),
    .SigQ      (SigQ),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .m_align   (m_align),
    .overrun   (overrun),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

`ifdef QAM_DEMOD_ERRCNT_EN
  localparam logic [15:0] ERR_MASK = 16'hFFFF;
`else
  localparam logic [15:0] ERR_MASK = 16'h0000;
`endif

  int          vecs = 0;
  int          errs = 0;
  logic        seq   [0:127];
  logic        obs_m [1:128];
  logic [15:0] obs_e [1:128];
  logic [1:0]  exp_sl [0:7] = '{2'b11, 2'b11, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01};
  logic [3:0]  exp4;
  logic [7:0]  exp8;
  logic [63:0] flips;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    vecs++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [2:0] lvl(input logic [1:0] d);
    case (d)
      2'b00:   return 3'b101;
      2'b01:   return 3'b111;
      2'b11:   return 3'b001;
      default: return 3'b011;
    endcase
  endfunction

  function automatic logic [15:0] exp_err(input int n);
    return 16'(n) & ERR_MASK;
  endfunction

  // Back-to-back symbols carrying the m-sequence, with selected bits flipped.
  // obs_*[k] are sampled while bit k is on bit_out.
  task automatic send_stream(input int nsym, input logic [63:0] fl);
    for (int j = 0; j < nsym; j++) begin
      logic [3:0] b;
      for (int i = 0; i < 4; i++) b[3-i] = seq[4*j+i] ^ fl[4*j+i+1];
      Siga      = lvl(b[3:2]);
      Sigb      = lvl(b[1:0]);
      sym_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
        step();
        sym_valid = 1'b0;
        obs_m[4*j+i+1] = m_align;
        obs_e[4*j+i+1] = err_cnt;
        chk("stream_bit", 16'(bit_out), 16'(b[3-i]));
      end
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    seq[0] = 1'b0;
    seq[1] = 1'b0;
    seq[2] = 1'b1;
    for (int n = 3; n < 128; n++) seq[n] = seq[n-2] ^ seq[n-3];

    rst = 1'b1; sym_valid = 1'b0; Siga = 3'b000; Sigb = 3'b000;
    step();
    step();
    chk("rst_SigI", 16'(SigI), 16'd0);
    chk("rst_SigQ", 16'(SigQ), 16'd0);
    chk("rst_bit_out", 16'(bit_out), 16'd0);
    chk("rst_bit_valid", 16'(bit_valid), 16'd0);
    chk("rst_m_align", 16'(m_align), 16'd0);
    chk("rst_overrun", 16'(overrun), 16'd0);
    chk("rst_err_cnt", err_cnt, 16'd0);
    rst = 1'b0;
    step();

    // All 8 codes on both rails, one symbol every 4 cycles.
    for (int i = 0; i < 8; i++) begin
      Siga = 3'(i); Sigb = 3'(7 - i); sym_valid = 1'b1;
      step();
      sym_valid = 1'b0;
      chk("slice_I", 16'(SigI), 16'(exp_sl[i]));
      chk("slice_Q", 16'(SigQ), 16'(exp_sl[7-i]));
      chk("slice_no_overrun", 16'(overrun), 16'd0);
      step(); step(); step();
    end

    // Siga=001, Sigb=111 -> bits 1,1,0,1.
    Siga = 3'b001; Sigb = 3'b111; sym_valid = 1'b1;
    step();
    sym_valid = 1'b0;
    chk("ser_SigI", 16'(SigI), 16'd3);
    chk("ser_SigQ", 16'(SigQ), 16'd1);
    exp4 = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      chk("ser_valid", 16'(bit_valid), 16'd1);
      chk("ser_bit", 16'(bit_out), 16'(exp4[3-i]));
      step();
    end
    chk("ser_valid_end", 16'(bit_valid), 16'd0);

    // sym_valid at t and t+2: second symbol dropped, overrun at t+3.
    Siga = 3'b011; Sigb = 3'b011; sym_valid = 1'b1;
    step();
    sym_valid = 1'b0;
    step();
    Siga = 3'b101; Sigb = 3'b101; sym_valid = 1'b1;
    step();
    sym_valid = 1'b0;
    chk("ovr_pulse", 16'(overrun), 16'd1);
    chk("ovr_SigI_held", 16'(SigI), 16'd2);
    chk("ovr_SigQ_held", 16'(SigQ), 16'd2);
    step();
    chk("ovr_pulse_end", 16'(overrun), 16'd0);
    chk("ovr_last_bit_valid", 16'(bit_valid), 16'd1);
    step();
    chk("ovr_dropped_no_bits", 16'(bit_valid), 16'd0);
    chk("ovr_SigI_after", 16'(SigI), 16'd2);

    // sym_valid at t and t+4: 8 contiguous bits 0110 then 1100.
    exp8 = 8'b0110_1100;
    for (int c = 0; c < 8; c++) begin
      if (c == 0) begin Siga = 3'b111; Sigb = 3'b010; sym_valid = 1'b1; end
      if (c == 4) begin Siga = 3'b000; Sigb = 3'b110; sym_valid = 1'b1; end
      step();
      sym_valid = 1'b0;
      chk("b2b_valid", 16'(bit_valid), 16'd1);
      chk("b2b_bit", 16'(bit_out), 16'(exp8[7-c]));
      chk("b2b_no_overrun", 16'(overrun), 16'd0);
    end
    chk("b2b_SigI", 16'(SigI), 16'd3);
    chk("b2b_SigQ", 16'(SigQ), 16'd0);
    step();
    chk("b2b_valid_end", 16'(bit_valid), 16'd0);

    // Clean lock, one isolated bit error, then 3 consecutive errors.
    pulse_reset();
    flips = 64'd0;
    flips[16] = 1'b1;
    flips[24] = 1'b1;
    flips[25] = 1'b1;
    flips[26] = 1'b1;
    send_stream(7, flips);
    chk("lock_before_bit10", 16'(obs_m[10]), 16'd0);
    chk("lock_after_bit10", 16'(obs_m[11]), 16'd1);
    chk("lock_err0", obs_e[11], 16'd0);
    chk("lock_err_pre_flip", obs_e[16], 16'd0);
    chk("flip1_err", obs_e[17], exp_err(1));
    chk("flip1_still_locked", 16'(obs_m[17]), 16'd1);
    chk("flip1_locked_later", 16'(obs_m[24]), 16'd1);
    chk("flip3_two_misses_locked", 16'(obs_m[26]), 16'd1);
    chk("flip3_err_partial", obs_e[26], exp_err(3));
    chk("flip3_unlock", 16'(obs_m[27]), 16'd0);
    chk("flip3_err", obs_e[27], exp_err(4));

    // All-zero input must never lock.
    pulse_reset();
    for (int j = 0; j < 8; j++) begin
      Siga = 3'b101; Sigb = 3'b101; sym_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
        step();
        sym_valid = 1'b0;
        chk("zeros_no_lock", 16'(m_align), 16'd0);
      end
    end
    step();
    chk("zeros_no_lock_end", 16'(m_align), 16'd0);

    // Locked with 5 errors, then reset mid-symbol with sym_valid high.
    pulse_reset();
    flips = 64'd0;
    flips[16] = 1'b1;
    flips[18] = 1'b1;
    flips[20] = 1'b1;
    flips[22] = 1'b1;
    flips[24] = 1'b1;
    send_stream(6, flips);
    Siga = lvl({seq[24], seq[25]}); Sigb = lvl({seq[26], seq[27]}); sym_valid = 1'b1;
    step();
    sym_valid = 1'b0;
    chk("pre_rst_err5", err_cnt, exp_err(5));
    chk("pre_rst_locked", 16'(m_align), 16'd1);
    step();
    rst = 1'b1; sym_valid = 1'b1; Siga = 3'b011; Sigb = 3'b011;
    step();
    rst = 1'b0; sym_valid = 1'b0;
    chk("mid_rst_SigI", 16'(SigI), 16'd0);
    chk("mid_rst_SigQ", 16'(SigQ), 16'd0);
    chk("mid_rst_bit_out", 16'(bit_out), 16'd0);
    chk("mid_rst_bit_valid", 16'(bit_valid), 16'd0);
    chk("mid_rst_m_align", 16'(m_align), 16'd0);
    chk("mid_rst_overrun", 16'(overrun), 16'd0);
    chk("mid_rst_err_cnt", err_cnt, 16'd0);
    step();
    chk("post_rst_abandoned", 16'(bit_valid), 16'd0);
    chk("post_rst_sym_ignored", 16'(SigI), 16'd0);
    chk("post_rst_err_cnt", err_cnt, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
